// File: rtl/core_pkg.sv
// Shared constants and the grant encoding for the writeback arbiter and its scoreboard.
package core_pkg;
    localparam int XLEN      = 32;
    localparam int REG_SEL_W = 5;
    localparam int NUM_REGS  = 32;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_ALU  = 2'd1,
        GNT_LSU  = 2'd2,
        GNT_DBG  = 2'd3
    } gnt_e;
endpackage

// File: rtl/wb_scoreboard.sv
// Register busy tracking: issue sets a bit, a landing writeback clears it, set wins a collision.
module wb_scoreboard
    import core_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 set_en,
    input  logic [REG_SEL_W-1:0] set_sel,
    input  logic                 clr_en,
    input  logic [REG_SEL_W-1:0] clr_sel,
    input  logic [REG_SEL_W-1:0] q_rs1,
    input  logic [REG_SEL_W-1:0] q_rs2,
    input  logic [REG_SEL_W-1:0] q_rd,
    output logic [NUM_REGS-1:0]  busy,
    output logic                 stall
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    always_comb begin
        busy_d = busy_q;
        if (clr_en)
            busy_d[clr_sel] = 1'b0;
        if (set_en)
            busy_d[set_sel] = 1'b1;
        // x0 is hardwired, so it can never be outstanding
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst)
            busy_q <= '0;
        else
            busy_q <= busy_d;
    end

    assign busy  = busy_q;
    assign stall = busy_q[q_rs1] | busy_q[q_rs2] | busy_q[q_rd];

endmodule

// File: rtl/wb_arbiter.sv
// Register-file writeback arbiter: debug > ALU/LSU round-robin on ties, one registered write per cycle.
module wb_arbiter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            lsu_valid,
    output logic            lsu_ready,
    input  logic [4:0]      lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    input  logic            dbg_wvalid,
    output logic            dbg_wready,
    input  logic [4:0]      dbg_wsel,
    input  logic [XLEN-1:0] dbg_wdata,
    output logic            rf_w_en,
    output logic [4:0]      rf_w_sel,
    output logic [XLEN-1:0] rf_w_data,
    input  logic            iss_en,
    input  logic [4:0]      iss_rd,
    input  logic [4:0]      q_rs1,
    input  logic [4:0]      q_rs2,
    input  logic [4:0]      q_rd,
    output logic            iss_stall,
    output logic [31:0]     sb_busy
);
    import core_pkg::*;

    gnt_e                 gnt;
    gnt_e                 last_grant_q, last_grant_d;
    logic [REG_SEL_W-1:0] wb_sel;
    logic [XLEN-1:0]      wb_data;
    logic                 rf_w_en_q, rf_w_en_d;
    logic [REG_SEL_W-1:0] rf_w_sel_q, rf_w_sel_d;
    logic [XLEN-1:0]      rf_w_data_q, rf_w_data_d;
    logic [NUM_REGS-1:0]  busy;

    // Debug only writes into a quiet machine so it never races an in-flight result.
    always_comb begin
        gnt = GNT_NONE;
        if (!rst) begin
            if (dbg_wvalid && (busy == '0))
                gnt = GNT_DBG;
            else if (alu_valid && lsu_valid)
                gnt = (last_grant_q == GNT_ALU) ? GNT_LSU : GNT_ALU;
            else if (alu_valid)
                gnt = GNT_ALU;
            else if (lsu_valid)
                gnt = GNT_LSU;
        end
    end

    assign dbg_wready = (gnt == GNT_DBG);
    assign alu_ready  = (gnt == GNT_ALU);
    assign lsu_ready  = (gnt == GNT_LSU);

    always_comb begin
        last_grant_d = last_grant_q;
        if (alu_valid && lsu_valid && (gnt == GNT_ALU || gnt == GNT_LSU))
            last_grant_d = gnt;

        case (gnt)
            GNT_DBG: begin wb_sel = dbg_wsel; wb_data = dbg_wdata; end
            GNT_LSU: begin wb_sel = lsu_rd;   wb_data = lsu_data;  end
            default: begin wb_sel = alu_rd;   wb_data = alu_data;  end
        endcase

        rf_w_en_d   = 1'b0;
        rf_w_sel_d  = rf_w_sel_q;
        rf_w_data_d = rf_w_data_q;
        if (gnt != GNT_NONE) begin
            rf_w_en_d   = (wb_sel != '0);
            rf_w_sel_d  = wb_sel;
            rf_w_data_d = wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_w_en_q    <= 1'b0;
            rf_w_sel_q   <= '0;
            rf_w_data_q  <= '0;
            last_grant_q <= GNT_LSU;
        end else begin
            rf_w_en_q    <= rf_w_en_d;
            rf_w_sel_q   <= rf_w_sel_d;
            rf_w_data_q  <= rf_w_data_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign rf_w_en   = rf_w_en_q;
    assign rf_w_sel  = rf_w_sel_q;
    assign rf_w_data = rf_w_data_q;

    // Clear keys off the registered write so busy drops as the RF value becomes readable.
    wb_scoreboard u_sb (
        .clk    (clk),
        .rst    (rst),
        .set_en (iss_en && (iss_rd != '0)),
        .set_sel(iss_rd),
        .clr_en (rf_w_en_q),
        .clr_sel(rf_w_sel_q),
        .q_rs1  (q_rs1),
        .q_rs2  (q_rs2),
        .q_rd   (q_rd),
        .busy   (busy),
        .stall  (iss_stall)
    );

    assign sb_busy = busy;

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus randomized traffic against a behavioural model.
module tb_wb_arbiter;
    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            alu_valid, alu_ready;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            lsu_valid, lsu_ready;
    logic [4:0]      lsu_rd;
    logic [XLEN-1:0] lsu_data;
    logic            dbg_wvalid, dbg_wready;
    logic [4:0]      dbg_wsel;
    logic [XLEN-1:0] dbg_wdata;
    logic            rf_w_en;
    logic [4:0]      rf_w_sel;
    logic [XLEN-1:0] rf_w_data;
    logic            iss_en;
    logic [4:0]      iss_rd;
    logic [4:0]      q_rs1, q_rs2, q_rd;
    logic            iss_stall;
    logic [31:0]     sb_busy;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [31:0]     m_busy;
    bit              m_last_alu;
    bit              m_en;
    logic [4:0]      m_sel;
    logic [XLEN-1:0] m_data;

    always #5 clk = ~clk;

    wb_arbiter #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .dbg_wvalid(dbg_wvalid), .dbg_wready(dbg_wready), .dbg_wsel(dbg_wsel), .dbg_wdata(dbg_wdata),
        .rf_w_en(rf_w_en), .rf_w_sel(rf_w_sel), .rf_w_data(rf_w_data),
        .iss_en(iss_en), .iss_rd(iss_rd),
        .q_rs1(q_rs1), .q_rs2(q_rs2), .q_rd(q_rd),
        .iss_stall(iss_stall), .sb_busy(sb_busy)
    );

    // Issuing into a hazard is a protocol violation by the issuer.
    always @(negedge clk)
        if (!rst && iss_en)
            assert (!iss_stall) else $error("illegal issue while iss_stall=1 (rd=%0d)", iss_rd);

    function automatic bit exp_dbg();
        return !rst && dbg_wvalid && (m_busy == 32'd0);
    endfunction
    function automatic bit exp_alu();
        return !rst && !exp_dbg() && alu_valid && (!lsu_valid || !m_last_alu);
    endfunction
    function automatic bit exp_lsu();
        return !rst && !exp_dbg() && !exp_alu() && lsu_valid;
    endfunction
    function automatic bit exp_stall();
        return m_busy[q_rs1] | m_busy[q_rs2] | m_busy[q_rd];
    endfunction

    // Advance one clock and move the model along with it; samples 1ns after the edge.
    task automatic tick();
        bit g_dbg, g_alu, g_lsu;
        logic [31:0] nb;
        g_dbg = exp_dbg();
        g_alu = exp_alu();
        g_lsu = exp_lsu();
        @(posedge clk);
        if (rst) begin
            m_busy = '0; m_last_alu = 1'b0; m_en = 1'b0; m_sel = '0; m_data = '0;
        end else begin
            nb = m_busy;
            if (m_en) nb[m_sel] = 1'b0;
            if (iss_en && iss_rd != 0) nb[iss_rd] = 1'b1;
            m_busy = nb;
            if (alu_valid && lsu_valid && (g_alu || g_lsu)) m_last_alu = g_alu;
            m_en = 1'b0;
            if (g_dbg)      begin m_sel = dbg_wsel; m_data = dbg_wdata; end
            else if (g_alu) begin m_sel = alu_rd;   m_data = alu_data;  end
            else if (g_lsu) begin m_sel = lsu_rd;   m_data = lsu_data;  end
            if (g_dbg || g_alu || g_lsu) m_en = (m_sel != 0);
        end
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
        dbg_wvalid = 0; dbg_wsel = 0; dbg_wdata = 0;
        iss_en = 0; iss_rd = 0; q_rs1 = 0; q_rs2 = 0; q_rd = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        alu_valid = 1; lsu_valid = 1; dbg_wvalid = 1; alu_rd = 3; lsu_rd = 4;
        #1;
        n_checks++;
        if ({alu_ready, lsu_ready, dbg_wready} !== 3'b000) begin
            n_errors++; $display("FAIL reset_readys: got %b want 000", {alu_ready, lsu_ready, dbg_wready});
        end
        tick(); tick();
        n_checks++;
        if (rf_w_en !== 1'b0 || rf_w_sel !== 5'd0 || rf_w_data !== '0) begin
            n_errors++; $display("FAIL reset_rf: got en=%b sel=%0d data=%h want 0/0/0", rf_w_en, rf_w_sel, rf_w_data);
        end
        n_checks++;
        if (sb_busy !== 32'd0) begin
            n_errors++; $display("FAIL reset_busy: got %h want 0", sb_busy);
        end
        idle_inputs();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_alu();
        alu_valid = 1; alu_rd = 5; alu_data = 32'h1111_1111;
        #1;
        n_checks++;
        if (alu_ready !== 1'b1 || lsu_ready !== 1'b0) begin
            n_errors++; $display("FAIL single_ready: got alu=%b lsu=%b want 1/0", alu_ready, lsu_ready);
        end
        tick();
        alu_valid = 0;
        n_checks++;
        if (rf_w_en !== 1'b1 || rf_w_sel !== 5'd5 || rf_w_data !== 32'h1111_1111) begin
            n_errors++; $display("FAIL single_write: got en=%b sel=%0d data=%h want 1/5/11111111", rf_w_en, rf_w_sel, rf_w_data);
        end
        tick();
        n_checks++;
        if (rf_w_en !== 1'b0 || rf_w_sel !== 5'd5 || rf_w_data !== 32'h1111_1111 || sb_busy !== 32'd0) begin
            n_errors++; $display("FAIL single_hold: got en=%b sel=%0d data=%h busy=%h want 0/5/11111111/0", rf_w_en, rf_w_sel, rf_w_data, sb_busy);
        end
    endtask

    task automatic test_tie();
        bit want_alu [4] = '{1, 0, 1, 0};
        do_reset();
        alu_valid = 1; lsu_valid = 1; alu_rd = 3; lsu_rd = 4;
        for (int i = 0; i < 4; i++) begin
            alu_data = 32'hA000_0000 + i; lsu_data = 32'hB000_0000 + i;
            #1;
            n_checks++;
            if (alu_ready !== want_alu[i] || lsu_ready !== !want_alu[i]) begin
                n_errors++; $display("FAIL tie_grant[%0d]: got alu=%b lsu=%b want alu=%b", i, alu_ready, lsu_ready, want_alu[i]);
            end
            tick();
            n_checks++;
            if (rf_w_en !== 1'b1 || rf_w_sel !== (want_alu[i] ? 5'd3 : 5'd4)
                || rf_w_data !== (want_alu[i] ? 32'hA000_0000 + i : 32'hB000_0000 + i)) begin
                n_errors++; $display("FAIL tie_write[%0d]: got en=%b sel=%0d data=%h", i, rf_w_en, rf_w_sel, rf_w_data);
            end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_hazard();
        iss_en = 1; iss_rd = 7;
        tick();
        iss_en = 0; q_rs1 = 7;
        tick();
        n_checks++;
        if (iss_stall !== 1'b1 || sb_busy[7] !== 1'b1) begin
            n_errors++; $display("FAIL hazard_set: got stall=%b busy7=%b want 1/1", iss_stall, sb_busy[7]);
        end
        lsu_valid = 1; lsu_rd = 7; lsu_data = 32'h0000_0777;
        tick();
        lsu_valid = 0;
        n_checks++;
        if (rf_w_en !== 1'b1 || rf_w_sel !== 5'd7 || iss_stall !== 1'b1) begin
            n_errors++; $display("FAIL hazard_landing: got en=%b sel=%0d stall=%b want 1/7/1", rf_w_en, rf_w_sel, iss_stall);
        end
        tick();
        n_checks++;
        if (iss_stall !== 1'b0 || sb_busy !== 32'd0) begin
            n_errors++; $display("FAIL hazard_clear: got stall=%b busy=%h want 0/0", iss_stall, sb_busy);
        end
        q_rs1 = 0;
    endtask

    task automatic test_same_edge();
        iss_en = 1; iss_rd = 9;
        tick();
        iss_en = 0;
        alu_valid = 1; alu_rd = 9; alu_data = 32'h9999;
        tick();
        alu_valid = 0;
        iss_en = 1; iss_rd = 9;
        tick();
        iss_en = 0;
        n_checks++;
        if (sb_busy[9] !== 1'b1) begin
            n_errors++; $display("FAIL same_edge_set_wins: got busy9=%b want 1", sb_busy[9]);
        end
        lsu_valid = 1; lsu_rd = 9; lsu_data = 32'h9A9A;
        tick();
        lsu_valid = 0;
        tick();
        n_checks++;
        if (sb_busy !== 32'd0) begin
            n_errors++; $display("FAIL same_edge_drain: got busy=%h want 0", sb_busy);
        end
    endtask

    task automatic test_dbg();
        iss_en = 1; iss_rd = 4;
        tick();
        iss_en = 0;
        dbg_wvalid = 1; dbg_wsel = 2; dbg_wdata = 32'hDEAD_BEEF;
        alu_valid = 1; alu_rd = 4; alu_data = 32'h0000_0444;
        #1;
        n_checks++;
        if (dbg_wready !== 1'b0 || alu_ready !== 1'b1) begin
            n_errors++; $display("FAIL dbg_blocked: got dbg=%b alu=%b want 0/1", dbg_wready, alu_ready);
        end
        tick();
        alu_rd = 6; alu_data = 32'h0000_0666;
        #1;
        n_checks++;
        if (dbg_wready !== 1'b0 || sb_busy[4] !== 1'b1) begin
            n_errors++; $display("FAIL dbg_wait_landing: got dbg=%b busy4=%b want 0/1", dbg_wready, sb_busy[4]);
        end
        tick();
        n_checks++;
        if (dbg_wready !== 1'b1 || alu_ready !== 1'b0 || sb_busy !== 32'd0) begin
            n_errors++; $display("FAIL dbg_grant: got dbg=%b alu=%b busy=%h want 1/0/0", dbg_wready, alu_ready, sb_busy);
        end
        tick();
        dbg_wvalid = 0;
        n_checks++;
        if (rf_w_en !== 1'b1 || rf_w_sel !== 5'd2 || rf_w_data !== 32'hDEAD_BEEF) begin
            n_errors++; $display("FAIL dbg_write: got en=%b sel=%0d data=%h want 1/2/deadbeef", rf_w_en, rf_w_sel, rf_w_data);
        end
        tick();
        alu_valid = 0;
        n_checks++;
        if (rf_w_en !== 1'b1 || rf_w_sel !== 5'd6 || rf_w_data !== 32'h0000_0666) begin
            n_errors++; $display("FAIL dbg_alu_after: got en=%b sel=%0d data=%h want 1/6/666", rf_w_en, rf_w_sel, rf_w_data);
        end
        tick();
    endtask

    task automatic test_rd0_and_reset();
        alu_valid = 1; alu_rd = 0; alu_data = 32'h0000_ABCD;
        #1;
        n_checks++;
        if (alu_ready !== 1'b1) begin
            n_errors++; $display("FAIL rd0_ready: got %b want 1", alu_ready);
        end
        tick();
        alu_valid = 0;
        n_checks++;
        if (rf_w_en !== 1'b0 || rf_w_sel !== 5'd0 || rf_w_data !== 32'h0000_ABCD) begin
            n_errors++; $display("FAIL rd0_write: got en=%b sel=%0d data=%h want 0/0/abcd", rf_w_en, rf_w_sel, rf_w_data);
        end
        lsu_valid = 1; lsu_rd = 3; lsu_data = 32'h3333;
        rst = 1;
        #1;
        n_checks++;
        if (lsu_ready !== 1'b0) begin
            n_errors++; $display("FAIL staged_reset_ready: got %b want 0", lsu_ready);
        end
        tick();
        rst = 0;
        lsu_valid = 0;
        n_checks++;
        if (rf_w_en !== 1'b0 || rf_w_data !== '0) begin
            n_errors++; $display("FAIL staged_reset_drop: got en=%b data=%h want 0/0", rf_w_en, rf_w_data);
        end
        tick();
        n_checks++;
        if (rf_w_en !== 1'b0) begin
            n_errors++; $display("FAIL post_reset_en: got %b want 0", rf_w_en);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst        = ($urandom_range(0, 63) == 0);
            alu_valid  = $urandom_range(0, 1);
            alu_rd     = $urandom_range(0, 31);
            alu_data   = $urandom;
            lsu_valid  = $urandom_range(0, 1);
            lsu_rd     = $urandom_range(0, 31);
            lsu_data   = $urandom;
            dbg_wvalid = ($urandom_range(0, 3) == 0);
            dbg_wsel   = $urandom_range(0, 31);
            dbg_wdata  = $urandom;
            q_rs1      = $urandom_range(0, 15);
            q_rs2      = $urandom_range(0, 15);
            q_rd       = $urandom_range(0, 15);
            #1;
            iss_en = !exp_stall() && ($urandom_range(0, 2) == 0);
            iss_rd = $urandom_range(0, 15);
            #1;
            n_checks++;
            if ({dbg_wready, alu_ready, lsu_ready} !== {exp_dbg(), exp_alu(), exp_lsu()}) begin
                n_errors++; $display("FAIL rand_ready[%0d]: got dbg/alu/lsu=%b want %b", c,
                    {dbg_wready, alu_ready, lsu_ready}, {exp_dbg(), exp_alu(), exp_lsu()});
            end
            n_checks++;
            if (iss_stall !== exp_stall()) begin
                n_errors++; $display("FAIL rand_stall[%0d]: got %b want %b", c, iss_stall, exp_stall());
            end
            tick();
            n_checks++;
            if (rf_w_en !== m_en || rf_w_sel !== m_sel || rf_w_data !== m_data) begin
                n_errors++; $display("FAIL rand_write[%0d]: got en=%b sel=%0d data=%h want %b/%0d/%h", c,
                    rf_w_en, rf_w_sel, rf_w_data, m_en, m_sel, m_data);
            end
            n_checks++;
            if (sb_busy !== m_busy) begin
                n_errors++; $display("FAIL rand_busy[%0d]: got %h want %h", c, sb_busy, m_busy);
            end
        end
        rst = 0;
        idle_inputs();
        tick();
    endtask

    initial begin
        idle_inputs();
        m_busy = '0; m_last_alu = 1'b0; m_en = 1'b0; m_sel = '0; m_data = '0;
        test_reset();
        test_single_alu();
        test_tie();
        test_hazard();
        test_same_edge();
        test_dbg();
        test_rd0_and_reset();
        do_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning the write-data width.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have ports alu_valid (in, 1), alu_ready (out, 1), alu_rd (in, 5) and alu_data (in, XLEN): the ALU writeback request.
REQ-005 The block SHALL have ports lsu_valid (in, 1), lsu_ready (out, 1), lsu_rd (in, 5) and lsu_data (in, XLEN): the load-unit writeback request.
REQ-006 The block SHALL have ports dbg_wvalid (in, 1), dbg_wready (out, 1), dbg_wsel (in, 5) and dbg_wdata (in, XLEN): the debugger register write.
REQ-007 The block SHALL have ports rf_w_en (out, 1), rf_w_sel (out, 5) and rf_w_data (out, XLEN): the register-file write port, all registered.
REQ-008 The block SHALL have ports iss_en (in, 1) and iss_rd (in, 5): an instruction issued that will write iss_rd.
REQ-009 The block SHALL have ports q_rs1, q_rs2 and q_rd (in, 5 each) and iss_stall (out, 1): the issue hazard query.
REQ-010 The block SHALL have port sb_busy, output, 32 bits: the scoreboard busy vector, bit 0 tied 0.

Function
REQ-011 The block SHALL accept at most one handshake (valid&&ready) per cycle; readys are combinational from the valids and state.
REQ-012 The block SHALL assert dbg_wready only when dbg_wvalid=1 and sb_busy==0; debug then has priority, and alu_ready=lsu_ready=0 that cycle.
REQ-013 When only one of ALU/LSU is valid and debug is not granted, the block SHALL grant that requester.
REQ-014 When both are valid, the block SHALL grant the one not recorded in last_grant, then set last_grant to the winner; debug grants leave last_grant unchanged.
REQ-015 On the edge after a handshake, the block SHALL drive rf_w_en=1, rf_w_sel=rd and rf_w_data=data for exactly one cycle; the latency is 1 cycle.
REQ-016 The block SHALL accept a handshake with rd=0 but SHALL keep rf_w_en=0 for it, while rf_w_sel and rf_w_data are still updated.
REQ-017 With no handshake, the block SHALL drive rf_w_en=0 and hold rf_w_sel and rf_w_data.
REQ-018 iss_en with iss_rd!=0 SHALL set sb_busy[iss_rd] on the next edge.
REQ-019 An edge with rf_w_en=1 SHALL clear sb_busy[rf_w_sel], so the bit drops in the same cycle the new value becomes readable from the register file.
REQ-020 When set and clear target the same register on one edge, the set SHALL win.
REQ-021 The block SHALL compute iss_stall = sb_busy[q_rs1] | sb_busy[q_rs2] | sb_busy[q_rd], combinationally; register 0 is never busy.
REQ-022 iss_en while iss_stall=1 is illegal; the block SHALL still set the bit, and the bench SHALL flag it by assertion.
REQ-023 A writeback to a non-busy rd SHALL be written normally and SHALL leave the scoreboard unchanged.

Reset
REQ-024 While rst=1 at an edge, the block SHALL clear rf_w_en, rf_w_sel, rf_w_data and sb_busy, and set last_grant=LSU so the ALU wins the first tie.
REQ-025 During reset all readys SHALL be 0, and a write staged before reset SHALL be dropped.
REQ-026 Reset mid-stream SHALL be ordinary synchronous reset with no partial write; rf_w_en=0 in the first cycle after reset.

Structure
REQ-027 Package core_pkg SHALL hold XLEN, REG_SEL_W=5, NUM_REGS=32 and the grant-encoding type (GNT_NONE/ALU/LSU/DBG).
REQ-028 The scoreboard (set, clear, query, busy vector) SHALL be one sub-module, wb_scoreboard; arbitration and the output register stay in wb_arbiter.

Verification
REQ-029 Scenario: reset, then alu_valid with rd=5, data=0x11111111 -> alu_ready=1; the next cycle rf_w_en=1, sel=5, data=0x11111111; the cycle after, rf_w_en=0.
REQ-030 Scenario: ALU and LSU both valid for 4 cycles (rd 3/4) -> grants ALU,LSU,ALU,LSU; each requester is stalled on its losing cycles.
REQ-031 Scenario: iss_en rd=7, then q_rs1=7 -> iss_stall=1 until the LSU write to 7 lands; iss_stall=0 in the cycle rf_w_en=1 is seen by the register file's next read.
REQ-032 Scenario: same edge iss_en rd=9 and rf_w_en sel=9 -> sb_busy[9]=1 afterwards.
REQ-033 Scenario: dbg_wvalid sel=2, data=0xDEADBEEF with sb_busy[4]=1 -> dbg_wready=0; after 4 clears, dbg_wready=1, ALU is blocked that cycle, and the write lands.
REQ-034 Scenario: ALU write to rd=0 -> handshake completes, rf_w_en stays 0; rst asserted with a write staged -> no rf_w_en pulse.
